// File: rtl/recovery_pkg.sv
// recovery_pkg
// Shared definitions for the multi-core error-recovery controller:
//   - state_e   : recovery FSM states, shared by the controller and its bench
//   - selWidth  : width of a core index for a given core count (at least 1)
//   - cntWidth  : width of a counter that must hold the values 0 .. n-1
package recovery_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RESET     = 3'd1,
    HALT      = 3'd2,
    HALT_WAIT = 3'd3,
    WORK_SPC  = 3'd4,
    WORK_SGPR = 3'd5,
    DONE      = 3'd6,
    FAIL      = 3'd7
  } state_e;

  // A single core still needs a 1-bit select so that port widths stay legal.
  function automatic int selWidth(input int numCores);
    return (numCores <= 1) ? 1 : $clog2(numCores);
  endfunction

  // Counter able to represent 0 .. n-1, never narrower than one bit.
  function automatic int cntWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/recovery_ctrl_rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin arbiter. It grants the first requesting
// index strictly after the last-served index, wrapping around, so the
// last-served core is considered last.
// Ports:
//   req_i        in   NUM_CORES  request vector (pending recoveries)
//   last_i       in   SEL_W      index served most recently
//   grant_o      out  NUM_CORES  one-hot grant, all zero when nothing requests
//   grant_idx_o  out  SEL_W      binary index of the granted request
module rr_arbiter
  import recovery_pkg::*;
#(
  parameter int NUM_CORES = 2
) (
  input  logic [NUM_CORES-1:0]           req_i,
  input  logic [selWidth(NUM_CORES)-1:0] last_i,
  output logic [NUM_CORES-1:0]           grant_o,
  output logic [selWidth(NUM_CORES)-1:0] grant_idx_o
);

  localparam int SEL_W = selWidth(NUM_CORES);

  // Walk the candidates in priority order starting one past the last-served
  // index; the final candidate visited is the last-served index itself.
  always_comb begin
    logic             found;
    int               cand;
    logic [SEL_W-1:0] candIdx;
    found       = 1'b0;
    cand        = 0;
    candIdx     = '0;
    grant_o     = '0;
    grant_idx_o = '0;
    for (int i = 1; i <= NUM_CORES; i++) begin
      cand    = (int'(last_i) + i) % NUM_CORES;
      candIdx = SEL_W'(cand);
      if (!found && req_i[candIdx]) begin
        found            = 1'b1;
        grant_o[candIdx] = 1'b1;
        grant_idx_o      = candIdx;
      end
    end
  end

endmodule

// File: rtl/recovery_ctrl.sv
// recovery_ctrl
// Multi-core error-recovery controller. Error reports from NUM_CORES cores are
// latched as pending; one core per episode is chosen round-robin, reset,
// halted, has its shadow PC and shadow GPRs replayed into it, and is resumed.
// A missing halt acknowledge triggers bounded retries, after which the core
// is marked failed (sticky) and its further errors are ignored.
// Ports:
//   clk_i           in   1           clock, rising edge
//   rst_i           in   1           asynchronous active-high reset
//   error_i         in   NUM_CORES   per-core error strobe/level
//   halted_i        in   NUM_CORES   per-core halt acknowledge
//   reset_o         out  NUM_CORES   per-core reset, active-low (1 = run)
//   halt_o          out  NUM_CORES   per-core halt request
//   resume_o        out  NUM_CORES   per-core resume pulse
//   shift_o         out  1           shadow-register shift/freeze enable
//   we_spc_o        out  1           shadow-PC write-back enable
//   we_sgpr_o       out  1           shadow-GPR write-back enable
//   replay_addr_o   out  ADDR_WIDTH  GPR write-back address
//   core_sel_o      out  SEL_W       core under recovery
//   busy_o          out  1           high whenever the FSM is not idle
//   fail_o          out  NUM_CORES   sticky per-core failed flag
//   recovery_cnt_o  out  8           completed recoveries, saturating at 255
module recovery_ctrl
  import recovery_pkg::*;
#(
  parameter int ADDR_WIDTH   = 5,
  parameter int NUM_CORES    = 2,
  parameter int HALT_TIMEOUT = 64,
  parameter int MAX_RETRY    = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_CORES-1:0]           error_i,
  input  logic [NUM_CORES-1:0]           halted_i,
  output logic [NUM_CORES-1:0]           reset_o,
  output logic [NUM_CORES-1:0]           halt_o,
  output logic [NUM_CORES-1:0]           resume_o,
  output logic                           shift_o,
  output logic                           we_spc_o,
  output logic                           we_sgpr_o,
  output logic [ADDR_WIDTH-1:0]          replay_addr_o,
  output logic [selWidth(NUM_CORES)-1:0] core_sel_o,
  output logic                           busy_o,
  output logic [NUM_CORES-1:0]           fail_o,
  output logic [7:0]                     recovery_cnt_o
);

  localparam int SEL_W = selWidth(NUM_CORES);
  localparam int TO_W  = cntWidth(HALT_TIMEOUT);
  localparam int RT_W  = cntWidth(MAX_RETRY + 1);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(HALT_TIMEOUT - 1);
  localparam logic [RT_W-1:0] RT_MAX  = RT_W'(MAX_RETRY);

  state_e                 state_q,   state_d;
  logic [SEL_W-1:0]       coreSel_q, coreSel_d;
  logic [SEL_W-1:0]       rrPtr_q,   rrPtr_d;
  logic [RT_W-1:0]        retry_q,   retry_d;
  logic [TO_W-1:0]        toCnt_q,   toCnt_d;
  logic [ADDR_WIDTH-1:0]  iter_q,    iter_d;
  logic [NUM_CORES-1:0]   pending_q, pending_d;
  logic [NUM_CORES-1:0]   fail_q,    fail_d;
  logic [7:0]             recCnt_q,  recCnt_d;
  logic [NUM_CORES-1:0]   clr;
  logic [NUM_CORES-1:0]   grant;
  logic [SEL_W-1:0]       grantIdx;

  rr_arbiter #(
    .NUM_CORES (NUM_CORES)
  ) uArbiter (
    .req_i       (pending_q),
    .last_i      (rrPtr_q),
    .grant_o     (grant),
    .grant_idx_o (grantIdx)
  );

  // All controller state lives here; reset puts the controller back to an
  // idle, nothing-pending, nothing-failed condition regardless of the clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      coreSel_q <= '0;
      rrPtr_q   <= '0;
      retry_q   <= '0;
      toCnt_q   <= '0;
      iter_q    <= '0;
      pending_q <= '0;
      fail_q    <= '0;
      recCnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      coreSel_q <= coreSel_d;
      rrPtr_q   <= rrPtr_d;
      retry_q   <= retry_d;
      toCnt_q   <= toCnt_d;
      iter_q    <= iter_d;
      pending_q <= pending_d;
      fail_q    <= fail_d;
      recCnt_q  <= recCnt_d;
    end
  end

  // Next-state logic for the recovery episode. The pending latch is updated
  // every cycle; the served core's bit is cleared in DONE or FAIL, but a new
  // error arriving in that same cycle wins so the report is not lost.
  always_comb begin
    state_d   = state_q;
    coreSel_d = coreSel_q;
    rrPtr_d   = rrPtr_q;
    retry_d   = retry_q;
    toCnt_d   = toCnt_q;
    iter_d    = iter_q;
    fail_d    = fail_q;
    recCnt_d  = recCnt_q;
    clr       = '0;

    case (state_q)
      IDLE: begin
        if (|grant) begin
          coreSel_d = grantIdx;
          retry_d   = '0;
          state_d   = RESET;
        end
      end
      RESET: state_d = HALT;
      HALT: begin
        toCnt_d = '0;
        state_d = HALT_WAIT;
      end
      HALT_WAIT: begin
        toCnt_d = toCnt_q + 1'b1;
        // An acknowledge on the final timeout cycle still counts as success.
        if (halted_i[coreSel_q]) begin
          state_d = WORK_SPC;
        end else if (toCnt_q == TO_LAST) begin
          if (retry_q < RT_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = RESET;
          end else begin
            state_d = FAIL;
          end
        end
      end
      WORK_SPC: begin
        iter_d  = '0;
        state_d = WORK_SGPR;
      end
      WORK_SGPR: begin
        iter_d = iter_q + 1'b1;
        if (iter_q == '1) state_d = DONE;
      end
      DONE: begin
        if (recCnt_q != 8'hFF) recCnt_d = recCnt_q + 8'd1;
        rrPtr_d          = coreSel_q;
        clr[coreSel_q]   = 1'b1;
        state_d          = IDLE;
      end
      FAIL: begin
        fail_d[coreSel_q] = 1'b1;
        clr[coreSel_q]    = 1'b1;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase

    pending_d = (pending_q & ~clr) | (error_i & ~fail_q);
  end

  // Moore output decode: only the selected core's bit of each per-core
  // vector ever leaves its idle value.
  always_comb begin
    reset_o       = '1;
    halt_o        = '0;
    resume_o      = '0;
    shift_o       = 1'b0;
    we_spc_o      = 1'b0;
    we_sgpr_o     = 1'b0;
    replay_addr_o = '0;
    case (state_q)
      RESET: reset_o[coreSel_q] = 1'b0;
      HALT: begin
        halt_o[coreSel_q] = 1'b1;
        shift_o           = 1'b1;
      end
      HALT_WAIT: shift_o = 1'b1;
      WORK_SPC: begin
        we_spc_o = 1'b1;
        shift_o  = 1'b1;
      end
      WORK_SGPR: begin
        we_sgpr_o     = 1'b1;
        replay_addr_o = iter_q;
      end
      DONE: resume_o[coreSel_q] = 1'b1;
      default: ;
    endcase
  end

  assign core_sel_o     = coreSel_q;
  assign busy_o         = (state_q != IDLE);
  assign fail_o         = fail_q;
  assign recovery_cnt_o = recCnt_q;

endmodule

// File: tb/tb_recovery_ctrl.sv
// tb_recovery_ctrl
// Self-checking bench for recovery_ctrl (2 cores, 32 GPRs, HALT_TIMEOUT=4,
// MAX_RETRY=2). Expectations come from an episode-level model: a pending
// vector, a last-served index, sticky failure flags and a recovery count,
// with each episode's pulse counts and length derived arithmetically.
module tb_recovery_ctrl;

  localparam int AW      = 5;
  localparam int NC      = 2;
  localparam int T       = 4;
  localparam int MR      = 2;
  localparam int NUM_REG = 1 << AW;

  logic          clk;
  logic          rst;
  logic [NC-1:0] errorIn;
  logic [NC-1:0] haltedIn;
  logic [NC-1:0] resetOut;
  logic [NC-1:0] haltOut;
  logic [NC-1:0] resumeOut;
  logic          shiftOut;
  logic          weSpc;
  logic          weSgpr;
  logic [AW-1:0] replayAddr;
  logic [0:0]    coreSel;
  logic          busy;
  logic [NC-1:0] failOut;
  logic [7:0]    recCnt;

  int total = 0;
  int bad   = 0;

  logic [NC-1:0] modelPending;
  logic [NC-1:0] modelFail;
  int            modelLast;
  int            modelCnt;

  recovery_ctrl #(
    .ADDR_WIDTH   (AW),
    .NUM_CORES    (NC),
    .HALT_TIMEOUT (T),
    .MAX_RETRY    (MR)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .error_i        (errorIn),
    .halted_i       (haltedIn),
    .reset_o        (resetOut),
    .halt_o         (haltOut),
    .resume_o       (resumeOut),
    .shift_o        (shiftOut),
    .we_spc_o       (weSpc),
    .we_sgpr_o      (weSgpr),
    .replay_addr_o  (replayAddr),
    .core_sel_o     (coreSel),
    .busy_o         (busy),
    .fail_o         (failOut),
    .recovery_cnt_o (recCnt)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counted always, reported only when it does not hold.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Round-robin choice: first pending core strictly after the last served.
  function automatic int modelPick();
    for (int i = 1; i <= NC; i++) begin
      int c;
      c = (modelLast + i) % NC;
      if (modelPending[c]) return c;
    end
    return -1;
  endfunction

  // One-cycle error strobe, called at a falling edge while the DUT is idle.
  task automatic applyStimulus(input logic [NC-1:0] mask);
    errorIn = mask;
    @(negedge clk);
    errorIn = '0;
    modelPending = modelPending | (mask & ~modelFail);
  endtask

  task automatic checkResetValues(input string p);
    checkOutput({p, "_reset_o"},   32'(resetOut),   32'(2'b11));
    checkOutput({p, "_halt_o"},    32'(haltOut),    0);
    checkOutput({p, "_resume_o"},  32'(resumeOut),  0);
    checkOutput({p, "_shift_o"},   32'(shiftOut),   0);
    checkOutput({p, "_we_spc"},    32'(weSpc),      0);
    checkOutput({p, "_we_sgpr"},   32'(weSgpr),     0);
    checkOutput({p, "_addr"},      32'(replayAddr), 0);
    checkOutput({p, "_core_sel"},  32'(coreSel),    0);
    checkOutput({p, "_busy"},      32'(busy),       0);
    checkOutput({p, "_fail"},      32'(failOut),    0);
    checkOutput({p, "_rec_cnt"},   32'(recCnt),     0);
  endtask

  // Follows one recovery episode of expCore. The bench acts as the core:
  // it acknowledges halt in HALT_WAIT cycle ackAt of every attempt (never if
  // ackAt >= T), toggles the other cores' halted bits randomly, and with
  // errActive raises a held error on the active core at GPR errAddr.
  task automatic runEpisode(input int expCore, input int ackAt,
                            input bit errActive, input int errAddr);
    int  cyc, busyCycles, resets, halts, shifts, spcs, resumes;
    int  nextAddr, addrErrs, selErrs, otherErrs, spacingErrs, lastReset, hwIdx;
    bit  ackOk;
    int  expBusy;
    cyc = 0; busyCycles = 0; resets = 0; halts = 0; shifts = 0; spcs = 0;
    resumes = 0; nextAddr = 0; addrErrs = 0; selErrs = 0; otherErrs = 0;
    spacingErrs = 0; lastReset = -1; hwIdx = -1;
    ackOk = (ackAt < T);

    while (busy !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("episode_start", 32'(busy), 1);
    if (busy !== 1'b1) return;

    while (busy === 1'b1 && busyCycles < 400) begin
      busyCycles++;
      if (int'(coreSel) != expCore) selErrs++;
      for (int j = 0; j < NC; j++) begin
        if (j != expCore && (resetOut[j] !== 1'b1 || haltOut[j] !== 1'b0 ||
                             resumeOut[j] !== 1'b0)) otherErrs++;
      end
      if (resetOut[expCore] === 1'b0) begin
        if (lastReset >= 0 && busyCycles - lastReset != T + 2) spacingErrs++;
        lastReset = busyCycles;
        resets++;
      end
      if (haltOut[expCore] === 1'b1) halts++;
      if (shiftOut === 1'b1) shifts++;
      if (weSpc === 1'b1) spcs++;
      if (resumeOut[expCore] === 1'b1) resumes++;
      if (weSgpr === 1'b1) begin
        if (int'(replayAddr) != nextAddr) addrErrs++;
        nextAddr++;
        if (errActive && int'(replayAddr) == errAddr) errorIn[expCore] = 1'b1;
      end
      if (haltOut[expCore] === 1'b1) begin
        hwIdx = 0;
        haltedIn[expCore] = 1'b0;
      end else if (weSpc === 1'b1) begin
        hwIdx = -1;
        haltedIn[expCore] = 1'b0;
      end else if (hwIdx >= 0) begin
        haltedIn[expCore] = (hwIdx >= ackAt);
        hwIdx++;
      end
      for (int j = 0; j < NC; j++)
        if (j != expCore) haltedIn[j] = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    errorIn  = '0;
    haltedIn = '0;
    checkOutput("episode_end", 32'(busy), 0);

    expBusy = ackOk ? NUM_REG + 5 + ackAt : (MR + 1) * (T + 2) + 1;
    checkOutput("busy_cycles",   busyCycles, expBusy);
    checkOutput("reset_pulses",  resets,  ackOk ? 1 : MR + 1);
    checkOutput("halt_pulses",   halts,   ackOk ? 1 : MR + 1);
    checkOutput("shift_cycles",  shifts,  ackOk ? ackAt + 3 : (MR + 1) * (T + 1));
    checkOutput("spc_pulses",    spcs,    ackOk ? 1 : 0);
    checkOutput("resume_pulses", resumes, ackOk ? 1 : 0);
    checkOutput("gpr_addr_count", nextAddr, ackOk ? NUM_REG : 0);
    checkOutput("gpr_addr_order", addrErrs, 0);
    checkOutput("core_sel_hold",  selErrs, 0);
    checkOutput("other_core_idle", otherErrs, 0);
    checkOutput("retry_spacing",  spacingErrs, 0);

    if (ackOk) begin
      modelCnt  = (modelCnt < 255) ? modelCnt + 1 : 255;
      modelLast = expCore;
    end else begin
      modelFail[expCore] = 1'b1;
    end
    if (!(errActive && ackOk)) modelPending[expCore] = 1'b0;
    checkOutput("recovery_cnt", 32'(recCnt), modelCnt);
    checkOutput("fail_flags",   32'(failOut), 32'(modelFail));
  endtask

  task automatic checkStaysIdle(input string tag, input int cycles);
    int busySeen;
    busySeen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (busy !== 1'b0) busySeen++;
    end
    checkOutput(tag, busySeen, 0);
  endtask

  initial begin
    logic [NC-1:0] mask;
    int            cyc;
    int            r;
    rst = 1'b1; errorIn = '0; haltedIn = '0;
    modelPending = '0; modelFail = '0; modelLast = 0; modelCnt = 0;
    repeat (2) @(negedge clk);
    checkResetValues("por");
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] single error on core 0, immediate halt ack");
    applyStimulus(2'b01);
    runEpisode(modelPick(), 0, 1'b0, 0);

    $display("[TB] simultaneous errors, then a repeat");
    for (int rep = 0; rep < 2; rep++) begin
      applyStimulus(2'b11);
      while (modelPending != '0)
        runEpisode(modelPick(), int'($urandom_range(0, T - 1)), 1'b0, 0);
    end

    $display("[TB] halt ack on the final timeout cycle");
    applyStimulus(2'b10);
    runEpisode(modelPick(), T - 1, 1'b0, 0);

    $display("[TB] error on the active core during GPR replay");
    applyStimulus(2'b01);
    runEpisode(modelPick(), 1, 1'b1, int'($urandom_range(0, NUM_REG - 1)));
    runEpisode(modelPick(), 0, 1'b0, 0);

    $display("[TB] halt never acknowledged");
    applyStimulus(2'b01);
    runEpisode(modelPick(), 1000, 1'b0, 0);
    applyStimulus(2'b01);
    checkStaysIdle("failed_core_masked", 10);

    $display("[TB] randomized error bursts");
    for (int it = 0; it < 4; it++) begin
      mask = 2'($urandom_range(1, 3));
      applyStimulus(mask);
      while (modelPending != '0)
        runEpisode(modelPick(), int'($urandom_range(0, T - 1)), 1'b0, 0);
      checkStaysIdle("idle_after_burst", 2);
    end

    $display("[TB] asynchronous reset during GPR replay");
    r = int'($urandom_range(1, NUM_REG - 2));
    errorIn  = 2'b10;
    haltedIn = 2'b10;
    cyc = 0;
    while (!(weSgpr === 1'b1 && int'(replayAddr) == r) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("reached_gpr_replay", 32'(weSgpr), 1);
    errorIn = '0;
    #2 rst = 1'b1;
    #1 checkResetValues("async");
    @(negedge clk);
    rst = 1'b0;
    haltedIn = '0;
    modelPending = '0; modelFail = '0; modelLast = 0; modelCnt = 0;
    checkStaysIdle("pending_cleared", 10);

    $display("[TB] recovery of core 0 after reset clears its failure");
    applyStimulus(2'b01);
    runEpisode(modelPick(), int'($urandom_range(0, T - 1)), 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
